// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller and its interval timer.
package traffic_pkg;

  typedef enum logic [1:0] {
    T_BASE = 2'b00,
    T_EXT  = 2'b01,
    T_YEL  = 2'b10
  } interval_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } timer_state_e;

  localparam int DEF_T_BASE = 6;
  localparam int DEF_T_EXT  = 3;
  localparam int DEF_T_YEL  = 2;

endpackage

// File: rtl/one_hz_divider.sv
// Free-running 0..CLK_DIV-1 counter; tick is decoded from the count register.
module one_hz_divider #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval store and one-second countdown that times the traffic-light FSM;
// also turns reprogramming writes into a one-cycle restart pulse.
module interval_timer_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_DIV  = 50_000_000,
  parameter int VAL_W    = 4,
  parameter int DEF_BASE = DEF_T_BASE,
  parameter int DEF_EXT  = DEF_T_EXT,
  parameter int DEF_YEL  = DEF_T_YEL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_timer,
  input  logic [1:0]       requesting_interval,
  input  logic             prog_sync,
  input  logic [1:0]       prog_sel,
  input  logic [VAL_W-1:0] prog_val,
  output logic             expired,
  output logic             reprogram,
  output logic             one_hz_en,
  output logic [VAL_W-1:0] remaining,
  output logic             busy
);

  localparam logic [VAL_W-1:0] DEF_BASE_V = VAL_W'(DEF_BASE);
  localparam logic [VAL_W-1:0] DEF_EXT_V  = VAL_W'(DEF_EXT);
  localparam logic [VAL_W-1:0] DEF_YEL_V  = VAL_W'(DEF_YEL);

  timer_state_e     state_q, state_d;
  logic [VAL_W-1:0] remaining_q, remaining_d;
  logic [VAL_W-1:0] t_base_q, t_ext_q, t_yel_q;
  logic [VAL_W-1:0] sel_val;
  logic             expired_q, busy_q, reprogram_q;
  logic             prog_accept, load, tick;

  // A write always beats a simultaneous load; the FSM restarts from reprogram.
  assign prog_accept = prog_sync && (prog_sel != 2'b11);
  assign load        = start_timer && !prog_accept;

  one_hz_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (load),
    .tick   (tick)
  );

  always_comb begin
    case (requesting_interval)
      T_EXT:   sel_val = t_ext_q;
      T_YEL:   sel_val = t_yel_q;
      default: sel_val = t_base_q;
    endcase
  end

  // A written zero maps back to the default so no interval can ever be zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_base_q <= DEF_BASE_V;
      t_ext_q  <= DEF_EXT_V;
      t_yel_q  <= DEF_YEL_V;
    end else if (prog_accept) begin
      case (prog_sel)
        2'b00:   t_base_q <= (prog_val == '0) ? DEF_BASE_V : prog_val;
        2'b01:   t_ext_q  <= (prog_val == '0) ? DEF_EXT_V  : prog_val;
        2'b10:   t_yel_q  <= (prog_val == '0) ? DEF_YEL_V  : prog_val;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (prog_accept) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (start_timer) begin
      state_d     = RUN;
      remaining_d = sel_val;
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            if (remaining_q == VAL_W'(1)) begin
              state_d     = EXPIRED;
              remaining_d = '0;
            end else begin
              remaining_d = remaining_q - VAL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with remaining.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      expired_q   <= 1'b0;
      busy_q      <= 1'b0;
      reprogram_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      expired_q   <= (state_d == EXPIRED);
      busy_q      <= (state_d == RUN);
      reprogram_q <= prog_accept;
    end
  end

  assign expired   = expired_q;
  assign busy      = busy_q;
  assign reprogram = reprogram_q;
  assign remaining = remaining_q;
  assign one_hz_en = tick;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed scoreboard bench for interval_timer_ctrl with a 4-cycle second.
module tb_interval_timer_ctrl;

  localparam int CLK_DIV = 4;
  localparam int VAL_W   = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start_timer;
  logic [1:0]       requesting_interval;
  logic             prog_sync;
  logic [1:0]       prog_sel;
  logic [VAL_W-1:0] prog_val;
  logic             expired, reprogram, one_hz_en, busy;
  logic [VAL_W-1:0] remaining;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  compared   = 0;
  int  mismatched = 0;

  interval_timer_ctrl #(
    .CLK_DIV(CLK_DIV),
    .VAL_W  (VAL_W)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start_timer        (start_timer),
    .requesting_interval(requesting_interval),
    .prog_sync          (prog_sync),
    .prog_sel           (prog_sel),
    .prog_val           (prog_val),
    .expired            (expired),
    .reprogram          (reprogram),
    .one_hz_en          (one_hz_en),
    .remaining          (remaining),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    sb_t e;
    compared++;
    if (sbq.size() == 0) begin
      mismatched++;
      $error("FAIL sb_empty: observed %0d with no expectation queued", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        mismatched++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic expectNow(input string tag, input logic [31:0] exp, input logic [31:0] obs);
    pushExp(tag, exp);
    checkOutput(obs);
  endtask

  // Drive one cycle of inputs; strobes are dropped again after the edge.
  task automatic applyStimulus(input logic st, input logic [1:0] ri, input logic ps,
                               input logic [1:0] psel, input logic [VAL_W-1:0] pval);
    start_timer         = st;
    requesting_interval = ri;
    prog_sync           = ps;
    prog_sel            = psel;
    prog_val            = pval;
    tick();
    start_timer = 1'b0;
    prog_sync   = 1'b0;
  endtask

  task automatic measureExpiry(input string tag, input int expCycles);
    int n;
    n = 0;
    pushExp(tag, 32'(expCycles));
    while (expired !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checkOutput(32'(n));
  endtask

  task automatic checkAllZero(input string tag);
    expectNow({tag, "_expired"},   0, 32'(expired));
    expectNow({tag, "_reprogram"}, 0, 32'(reprogram));
    expectNow({tag, "_one_hz"},    0, 32'(one_hz_en));
    expectNow({tag, "_remaining"}, 0, 32'(remaining));
    expectNow({tag, "_busy"},      0, 32'(busy));
  endtask

  initial begin
    int highs;
    reset_n             = 1'b0;
    start_timer         = 1'b0;
    requesting_interval = 2'b00;
    prog_sync           = 1'b0;
    prog_sel            = 2'b00;
    prog_val            = '0;

    #12;
    checkAllZero("reset");
    #10;
    reset_n = 1'b1;
    tick();
    expectNow("post_reset_busy", 0, 32'(busy));

    // Scenario 1: base interval from reset defaults
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    expectNow("s1_load_rem", 6, 32'(remaining));
    expectNow("s1_load_busy", 1, 32'(busy));
    expectNow("s1_load_expired", 0, 32'(expired));
    measureExpiry("s1_expiry_cycles", 24);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (expired === 1'b1 && remaining === '0 && busy === 1'b0) highs++;
    end
    expectNow("s1_expired_hold", 10, 32'(highs));

    // Scenario 2: yellow interval, expectations queued at load time
    applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, '0);
    expectNow("s2_load_rem", 2, 32'(remaining));
    expectNow("s2_load_expired", 0, 32'(expired));
    for (int k = 1; k <= 8; k++) begin
      pushExp($sformatf("s2_rem_c%0d", k), (k < 4) ? 2 : (k < 8) ? 1 : 0);
      pushExp($sformatf("s2_tick_c%0d", k), (k == 3 || k == 7) ? 1 : 0);
      pushExp($sformatf("s2_exp_c%0d", k), (k == 8) ? 1 : 0);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput(32'(remaining));
      checkOutput(32'(one_hz_en));
      checkOutput(32'(expired));
    end
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, '0);
    expectNow("s2_reload_expired", 0, 32'(expired));
    expectNow("s2_reload_rem", 3, 32'(remaining));
    expectNow("s2_reload_busy", 1, 32'(busy));

    // Scenario 3: reprogram ext to 5, then restore default with 0
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b01, 4'd5);
    expectNow("s3_reprog_pulse", 1, 32'(reprogram));
    expectNow("s3_abort_busy", 0, 32'(busy));
    expectNow("s3_abort_rem", 0, 32'(remaining));
    tick();
    expectNow("s3_reprog_drop", 0, 32'(reprogram));
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, '0);
    expectNow("s3_ext5_rem", 5, 32'(remaining));
    measureExpiry("s3_ext5_cycles", 20);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b01, 4'd0);
    expectNow("s3_restore_pulse", 1, 32'(reprogram));
    expectNow("s3_restore_expired", 0, 32'(expired));
    tick();
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, '0);
    expectNow("s3_ext3_rem", 3, 32'(remaining));
    measureExpiry("s3_ext3_cycles", 12);

    // Scenario 5: restart mid-count with ext
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    for (int i = 0; i < 8; i++) tick();
    expectNow("s5_mid_rem", 4, 32'(remaining));
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, '0);
    expectNow("s5_restart_rem", 3, 32'(remaining));
    measureExpiry("s5_restart_cycles", 12);

    // Scenario 4: write collides with load during RUN; write wins
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 2'b01, 1'b1, 2'b00, 4'd9);
    expectNow("s4_col_busy", 0, 32'(busy));
    expectNow("s4_col_rem", 0, 32'(remaining));
    expectNow("s4_col_expired", 0, 32'(expired));
    expectNow("s4_col_reprog", 1, 32'(reprogram));
    tick();
    expectNow("s4_col_reprog_drop", 0, 32'(reprogram));
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (expired !== 1'b0 || busy !== 1'b0 || reprogram !== 1'b0) highs++;
    end
    expectNow("s4_idle_quiet", 0, 32'(highs));
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    expectNow("s4_base9_rem", 9, 32'(remaining));
    tick();
    tick();
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b11, 4'd1);
    expectNow("s4_sel11_reprog", 0, 32'(reprogram));
    expectNow("s4_sel11_busy", 1, 32'(busy));
    expectNow("s4_sel11_rem", 9, 32'(remaining));
    measureExpiry("s4_base9_cycles", 33);

    // Scenario 6: asynchronous reset mid-count restores defaults
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    for (int i = 0; i < 5; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checkAllZero("s6_async");
    #10;
    reset_n = 1'b1;
    tick();
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    expectNow("s6_base_default_rem", 6, 32'(remaining));
    measureExpiry("s6_base_default_cycles", 24);

    if (sbq.size() != 0) begin
      mismatched++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
